// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the RV32I/RV64I decode stage. Fetched
// instructions arrive over a valid/ready handshake. Each one is classified by
// its full 7-bit opcode into R/I/S/B/U/J (or ILL). The block produces the
// sign- or zero-extended XLEN-bit immediate, a 3-bit format code and an
// illegal flag. The sideband tag passes through untouched.
//
// A one-entry output register plus a one-entry skid register keep one result
// per cycle flowing under backpressure. in_ready is taken from registered
// state only, so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the sideband tag
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   flush        synchronous flush, empties both entries
//   in_valid     instruction present
//   in_ready     block can accept an instruction (skid entry empty)
//   in_instr     32-bit instruction word
//   in_tag       sideband tag
//   out_valid    result present
//   out_ready    consumer accepts the result
//   out_imm      extended immediate
//   out_fmt      R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//   out_illegal  opcode not recognised
//   out_tag      tag of the result
//
// Optional build macro IMM_GEN_PERF_EN adds:
//   perf_sel     selects a per-format counter (5 and 7 both pick J/ILL)
//   perf_cnt     selected 32-bit saturating counter value
// With the macro undefined these ports and the counters do not exist.
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_PERF_EN
    ,
    input  logic [2:0]       perf_sel,
    output logic [31:0]      perf_cnt
`endif
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam bit RV64 = (XLEN == 64);

    // Decoded (not yet registered) view of in_instr.
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [63:0] dec_imm64;
    fmt_e        dec_fmt;
    logic        dec_ill;

    // Skid entry, only ever occupied while the output register is stalled.
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    logic in_xfer;
    logic out_xfer;

    assign in_ready = ~skid_valid;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Immediate decode. Everything is built at 64 bits and truncated to
    // XLEN afterwards; truncating a sign-extended value is still correctly
    // sign-extended, so RV32 needs no separate path except for shamt width
    // and the *W opcodes, which do not exist there.
    always_comb begin
        opcode    = in_instr[6:0];
        funct3    = in_instr[14:12];
        is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        dec_imm64 = 64'd0;
        dec_fmt   = FMT_ILL;
        dec_ill   = 1'b1;
        case (opcode)
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                dec_fmt   = FMT_I;
                dec_ill   = 1'b0;
                dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM: begin
                dec_fmt = FMT_I;
                dec_ill = 1'b0;
                if (is_shift) begin
                    // shamt is zero-extended; funct7 bits above it are not
                    // part of the immediate.
                    if (RV64) begin
                        dec_imm64 = {58'd0, in_instr[25:20]};
                    end else begin
                        dec_imm64 = {59'd0, in_instr[24:20]};
                    end
                end else begin
                    dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_IMM32: begin
                if (RV64) begin
                    dec_fmt = FMT_I;
                    dec_ill = 1'b0;
                    if (is_shift) begin
                        dec_imm64 = {59'd0, in_instr[24:20]};
                    end else begin
                        dec_imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
                    end
                end
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_ill   = 1'b0;
                dec_imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_ill   = 1'b0;
                dec_imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_ill   = 1'b0;
                dec_imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_ill   = 1'b0;
                dec_imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_REG: begin
                dec_fmt = FMT_R;
                dec_ill = 1'b0;
            end
            OP_REG32: begin
                if (RV64) begin
                    dec_fmt = FMT_R;
                    dec_ill = 1'b0;
                end
            end
            default: begin
                dec_fmt = FMT_ILL;
                dec_ill = 1'b1;
            end
        endcase
    end

    // Output register and skid entry. Flush wins over everything and drops
    // any input presented that cycle. When the output register is free (or
    // being taken) it is refilled from the skid entry first so order stays
    // FIFO; in_ready is low whenever the skid is full, so a new input can
    // never compete with a skid reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_fmt      <= 3'd0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_fmt     <= 3'd0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_xfer || !out_valid) begin
            if (skid_valid) begin
                out_valid   <= 1'b1;
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
                skid_valid  <= 1'b0;
            end else if (in_xfer) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm64[XLEN-1:0];
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm64[XLEN-1:0];
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_ill;
            skid_tag     <= in_tag;
        end
    end

`ifdef IMM_GEN_PERF_EN
    // Per-format counters: 0..4 map to R/I/S/B/U, slot 5 is shared by J and
    // ILL. They count output transfers and survive flush.
    logic [31:0] perf_ctr [6];
    logic [2:0]  perf_idx;

    always_comb begin
        perf_idx = (out_fmt >= 3'd5) ? 3'd5 : out_fmt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                perf_ctr[i] <= 32'd0;
            end
        end else if (out_xfer) begin
            for (int i = 0; i < 6; i++) begin
                if ((3'(i) == perf_idx) && (perf_ctr[i] != 32'hFFFF_FFFF)) begin
                    perf_ctr[i] <= perf_ctr[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        perf_cnt = 32'd0;
        case (perf_sel)
            3'd0: perf_cnt = perf_ctr[0];
            3'd1: perf_cnt = perf_ctr[1];
            3'd2: perf_cnt = perf_ctr[2];
            3'd3: perf_cnt = perf_ctr[3];
            3'd4: perf_cnt = perf_ctr[4];
            3'd5, 3'd7: perf_cnt = perf_ctr[5];
            default: perf_cnt = 32'd0;
        endcase
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Self-checking bench for imm_gen_pipe (default build, XLEN=64). A reference
// queue holds the expected results in acceptance order; every cycle the DUT
// handshake state and the head result are compared against it.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    exp_t model_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Reference decode from the RISC-V immediate rules, using shifts/masks
    // and arithmetic sign handling.
    function automatic exp_t refDecode(input logic [31:0] instr, input logic [7:0] tag);
        exp_t   r;
        longint w;
        longint v;
        int     op;
        int     f3;
        w  = longint'({32'd0, instr});
        op = int'(w & 127);
        f3 = int'((w >> 12) & 7);
        v  = 0;
        r.tag = tag;
        r.ill = 1'b0;
        r.fmt = 3'd1;
        case (op)
            'h03, 'h67, 'h73: v = sext(w >> 20, 12);
            'h13: v = (f3 == 1 || f3 == 5) ? ((w >> 20) & 63) : sext(w >> 20, 12);
            'h1B: v = (f3 == 1 || f3 == 5) ? ((w >> 20) & 31) : sext(w >> 20, 12);
            'h23: begin
                r.fmt = 3'd2;
                v = sext(((w >> 25) << 5) + ((w >> 7) & 31), 12);
            end
            'h63: begin
                r.fmt = 3'd3;
                v = sext(((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
                         ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2, 13);
            end
            'h37, 'h17: begin
                r.fmt = 3'd4;
                v = sext(w & 'hFFFFF000, 32);
            end
            'h6F: begin
                r.fmt = 3'd5;
                v = sext(((w >> 31) & 1) * 1048576 + ((w >> 12) & 255) * 4096 +
                         ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2, 21);
            end
            'h33, 'h3B: r.fmt = 3'd0;
            default: begin
                r.fmt = 3'd7;
                r.ill = 1'b1;
            end
        endcase
        r.imm = v;
        return r;
    endfunction

    // Compares handshake state and the head result against the queue.
    task automatic checkOutput();
        int sz;
        sz = model_q.size();
        check64("out_valid", {63'd0, out_valid}, {63'd0, (sz > 0)});
        check64("in_ready", {63'd0, in_ready}, {63'd0, (sz < 2)});
        if (sz > 0 && out_valid) begin
            check64("out_imm", out_imm, model_q[0].imm);
            check64("out_fmt", {61'd0, out_fmt}, {61'd0, model_q[0].fmt});
            check64("out_illegal", {63'd0, out_illegal}, {63'd0, model_q[0].ill});
            check64("out_tag", {56'd0, out_tag}, {56'd0, model_q[0].tag});
        end
    endtask

    // One cycle: drive at the falling edge, check, then advance the model
    // to reflect the transfers the coming rising edge will perform.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [7:0] tag,
                                 input logic rdy, input logic fl, output bit accepted);
        bit in_x;
        bit out_x;
        @(negedge clk);
        in_valid  = v;
        in_instr  = instr;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        #1;
        checkOutput();
        in_x  = v && in_ready;
        out_x = out_valid && rdy;
        if (out_x && model_q.size() > 0) void'(model_q.pop_front());
        if (fl) begin
            model_q.delete();
            accepted = 1'b0;
        end else begin
            if (in_x) model_q.push_back(refDecode(instr, tag));
            accepted = in_x;
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [6:0] ops [14];
        int idx;
        logic [6:0] op;
        ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0F};
        idx = $urandom_range(0, 14);
        op  = (idx == 14) ? 7'($urandom) : ops[idx];
        return {25'($urandom >> 7), op};
    endfunction

    initial begin
        vec_t vecs [14];
        bit   acc;
        bit   pending;
        logic [7:0] seen[$];

        vecs = '{
            '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0},
            '{32'hFE113C23, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 1'b0},
            '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0},
            '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0},
            '{32'h03F09093, 64'h0000_0000_0000_003F, 3'd1, 1'b0},
            '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd7, 1'b1},
            '{32'h00000033, 64'h0000_0000_0000_0000, 3'd0, 1'b0},
            '{32'hFFDFF06F, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 1'b0},
            '{32'h4010D093, 64'h0000_0000_0000_0001, 3'd1, 1'b0},
            '{32'h4010D09B, 64'h0000_0000_0000_0001, 3'd1, 1'b0},
            '{32'hFFF0809B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0},
            '{32'h00001097, 64'h0000_0000_0000_1000, 3'd4, 1'b0},
            '{32'h7FF02083, 64'h0000_0000_0000_07FF, 3'd1, 1'b0},
            '{32'h0000003B, 64'h0000_0000_0000_0000, 3'd0, 1'b0}
        };

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_tag    = 8'd0;
        out_ready = 1'b0;
        #12;
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("rst_out_imm", out_imm, 64'd0);
        check64("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
        check64("rst_out_tag", {56'd0, out_tag}, 64'd0);
        check64("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table vectors: accept, then the result must be present one cycle later.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 8'(i + 16), 1'b1, 1'b0, acc);
            applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);
            check64("vec_valid", {63'd0, out_valid}, 64'd1);
            check64("vec_imm", out_imm, vecs[i].imm);
            check64("vec_fmt", {61'd0, out_fmt}, {61'd0, vecs[i].fmt});
            check64("vec_ill", {63'd0, out_illegal}, {63'd0, vecs[i].ill});
            check64("vec_tag", {56'd0, out_tag}, 64'(i + 16));
        end

        // Backpressure: tags 1,2,3 with out_ready low, then drained in order.
        applyStimulus(1'b1, 32'hFFF00093, 8'd1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hFE113C23, 8'd2, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hFE000EE3, 8'd3, 1'b0, 1'b0, acc);
        check64("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        pending = !acc;
        seen.delete();
        for (int c = 0; c < 12 && seen.size() < 3; c++) begin
            applyStimulus(pending, 32'hFE000EE3, 8'd3, 1'b1, 1'b0, acc);
            if (acc) pending = 1'b0;
            if (out_valid) seen.push_back(out_tag);
        end
        check64("bp_count", 64'(seen.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check64("bp_order", (k < seen.size()) ? {56'd0, seen[k]} : 64'hDEAD, 64'(k + 1));
        end
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);

        // Flush with two results held and an input presented.
        applyStimulus(1'b1, 32'h00001097, 8'd10, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00001097, 8'd11, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'h00001097, 8'hAA, 1'b0, 1'b1, acc);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);
        check64("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check64("flush_in_ready", {63'd0, in_ready}, 64'd1);
        // Flush with the pipe empty and in_ready high: input still dropped.
        applyStimulus(1'b1, 32'h00001097, 8'hAB, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);
        check64("flush2_out_valid", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset mid-stream with two entries held.
        applyStimulus(1'b1, 32'hFFF00093, 8'd20, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 32'hFFF00093, 8'd21, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, acc);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check64("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("arst_out_imm", out_imm, 64'd0);
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b1, 32'h800000B7, 8'h55, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);
        check64("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check64("post_rst_tag", {56'd0, out_tag}, 64'h55);

        // Randomized traffic against the reference queue.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, randInstr(), 8'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, acc);
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 32'd0, 8'd0, 1'b1, 1'b0, acc);
        end
        check64("drain_empty", 64'(model_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
